vga_sync: RTL and testbench

Raster timing generator for the 640x480@60 Hz VGA output path. It divides the board clock down to a pixel-enable, runs the horizontal and vertical position counters, and decodes active-low sync and the visible-area flag. It is the stage directly upstream of the window/quadrant decode and the framebuffer address concatenation: its `r`/`c` outputs drive those stages. Its sync outputs are delayed to line up with the registered framebuffer read.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_counter.sv | 31 +++
 rtl/vga_sync.sv | 129 ++++++++++++
 tb/tb_vga_sync.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster timing path.
//   - Default 640x480@60 Hz timing constants and the derived line/frame totals.
//   - coord_t: the 10-bit row/column coordinate type used by every stage.
//   - to_coord(): integer-to-coordinate helper for building compare constants.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_VIS = 640;
  localparam int DEF_H_FP  = 16;
  localparam int DEF_H_SW  = 96;
  localparam int DEF_H_BP  = 48;
  localparam int DEF_V_VIS = 480;
  localparam int DEF_V_FP  = 10;
  localparam int DEF_V_SW  = 2;
  localparam int DEF_V_BP  = 33;

  localparam int DEF_H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SW + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SW + DEF_V_BP;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic coord_t to_coord(input int v);
    return coord_t'(v);
  endfunction

endpackage

// File: rtl/vga_counter.sv
// Wrapping position counter used for both the column and row axes.
//   clk   : board clock
//   rst_n : asynchronous active-low reset, clears q to 0
//   en    : advance enable
//   q     : current count, 0..MAX
//   wrap  : high while en is high and q == MAX (the step that returns q to 0)
module vga_counter
  import vga_pkg::*;
#(
  parameter int MAX = DEF_H_TOTAL - 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  output coord_t q,
  output logic   wrap
);

  localparam coord_t Q_MAX = to_coord(MAX);

  assign wrap = en && (q == Q_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= wrap ? '0 : q + coord_t'(1);
    end
  end

endmodule

// File: rtl/vga_sync.sv
// Raster timing generator for the VGA output path.
// Divides clk into a pixel enable, runs column/row counters and produces
// active-low hsync/vsync plus a visible-area flag. The sync/visible outputs
// are delayed SYNC_DELAY clks so they line up with the registered
// framebuffer read driven from r/c.
//   clk         : board clock, rising edge
//   rst_n       : asynchronous active-low reset
//   r, c        : current row / column (counter registers, no latency)
//   pix_en      : one-clk pulse; r/c advance on the edge where it is high
//   hs, vs      : active-low syncs, SYNC_DELAY clks behind r/c
//   video_on    : visible-area flag, SYNC_DELAY clks behind r/c
//   frame_start : one-clk pulse on the last pixel of a frame (undelayed)
module vga_sync
  import vga_pkg::*;
#(
  parameter int H_VIS      = DEF_H_VIS,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SW       = DEF_H_SW,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_VIS      = DEF_V_VIS,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SW       = DEF_V_SW,
  parameter int V_BP       = DEF_V_BP,
  parameter int CLK_DIV    = 2,
  parameter int SYNC_DELAY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [COORD_W-1:0] r,
  output logic [COORD_W-1:0] c,
  output logic               pix_en,
  output logic               hs,
  output logic               vs,
  output logic               video_on,
  output logic               frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SW + V_BP;

  localparam coord_t HS_FIRST = to_coord(H_VIS + H_FP);
  localparam coord_t HS_LAST  = to_coord(H_VIS + H_FP + H_SW - 1);
  localparam coord_t VS_FIRST = to_coord(V_VIS + V_FP);
  localparam coord_t VS_LAST  = to_coord(V_VIS + V_FP + V_SW - 1);
  localparam coord_t H_VIS_C  = to_coord(H_VIS);
  localparam coord_t V_VIS_C  = to_coord(V_VIS);

  // CLK_DIV is at most 8, so the divider never exceeds 7.
  localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);

  logic [2:0] div_cnt;
  coord_t     col_q;
  coord_t     row_q;
  logic       col_wrap;
  logic       row_wrap;
  logic       hs_d;
  logic       vs_d;
  logic       von_d;

  logic [SYNC_DELAY-1:0] hs_pipe;
  logic [SYNC_DELAY-1:0] vs_pipe;
  logic [SYNC_DELAY-1:0] von_pipe;

  assign pix_en = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 3'd1;
    end
  end

  vga_counter #(
    .MAX (H_TOTAL - 1)
  ) u_col (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .q     (col_q),
    .wrap  (col_wrap)
  );

  vga_counter #(
    .MAX (V_TOTAL - 1)
  ) u_row (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (col_wrap),
    .q     (row_q),
    .wrap  (row_wrap)
  );

  assign r = row_q;
  assign c = col_q;

  // Row wrap is only possible on a column wrap, which itself requires
  // pix_en, so it is exactly the last-pixel-of-frame condition.
  assign frame_start = row_wrap;

  assign hs_d  = !((col_q >= HS_FIRST) && (col_q <= HS_LAST));
  assign vs_d  = !((row_q >= VS_FIRST) && (row_q <= VS_LAST));
  assign von_d = (col_q < H_VIS_C) && (row_q < V_VIS_C);

  // Free-running on clk (not pix_en) so the delay is counted in clks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_pipe  <= '1;
      vs_pipe  <= '1;
      von_pipe <= '0;
    end else begin
      hs_pipe[0]  <= hs_d;
      vs_pipe[0]  <= vs_d;
      von_pipe[0] <= von_d;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
        von_pipe[i] <= von_pipe[i-1];
      end
    end
  end

  assign hs       = hs_pipe[SYNC_DELAY-1];
  assign vs       = vs_pipe[SYNC_DELAY-1];
  assign video_on = von_pipe[SYNC_DELAY-1];

endmodule

// File: tb/tb_vga_sync.sv
module tb_vga_sync;

  typedef struct {
    int r;
    int c;
    bit pe;
    bit hs;
    bit vs;
    bit von;
    bit fs;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [9:0] d_r, d_c, s_r, s_c, k_r, k_c;
  logic d_pe, d_hs, d_vs, d_von, d_fs;
  logic s_pe, s_hs, s_vs, s_von, s_fs;
  logic k_pe, k_hs, k_vs, k_von, k_fs;
  logic [24:0] d_obs, s_obs, k_obs;

  int n_cmp = 0;
  int n_bad = 0;
  longint n = 0;

  assign d_obs = {d_r, d_c, d_pe, d_hs, d_vs, d_von, d_fs};
  assign s_obs = {s_r, s_c, s_pe, s_hs, s_vs, s_von, s_fs};
  assign k_obs = {k_r, k_c, k_pe, k_hs, k_vs, k_von, k_fs};

  always #5 clk = ~clk;

  // Number of rising edges seen since reset was released.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  vga_sync u_def (
    .clk(clk), .rst_n(rst_n), .r(d_r), .c(d_c), .pix_en(d_pe),
    .hs(d_hs), .vs(d_vs), .video_on(d_von), .frame_start(d_fs)
  );

  vga_sync #(
    .H_VIS(20), .H_FP(4), .H_SW(6), .H_BP(5),
    .V_VIS(10), .V_FP(2), .V_SW(3), .V_BP(4),
    .CLK_DIV(3), .SYNC_DELAY(2)
  ) u_sml (
    .clk(clk), .rst_n(rst_n), .r(s_r), .c(s_c), .pix_en(s_pe),
    .hs(s_hs), .vs(s_vs), .video_on(s_von), .frame_start(s_fs)
  );

  vga_sync #(
    .CLK_DIV(1), .SYNC_DELAY(3)
  ) u_cor (
    .clk(clk), .rst_n(rst_n), .r(k_r), .c(k_c), .pix_en(k_pe),
    .hs(k_hs), .vs(k_vs), .video_on(k_von), .frame_start(k_fs)
  );

  // Position after n edges is pixel index n/div laid out on an ht x vt raster;
  // delayed outputs show the raster decode of the position dly edges earlier.
  function automatic exp_t model(input longint nn, input int hv, input int hfp,
                                 input int hsw, input int hbp, input int vv,
                                 input int vfp, input int vsw, input int vbp,
                                 input int div, input int dly);
    exp_t   e;
    longint p, q;
    int     ht, vt, cc, rr;
    ht    = hv + hfp + hsw + hbp;
    vt    = vv + vfp + vsw + vbp;
    p     = nn / div;
    e.c   = int'(p % ht);
    e.r   = int'((p / ht) % vt);
    e.pe  = ((nn % div) == div - 1);
    e.fs  = e.pe && (e.r == vt - 1) && (e.c == ht - 1);
    if (nn < dly) begin
      e.hs  = 1'b1;
      e.vs  = 1'b1;
      e.von = 1'b0;
    end else begin
      q     = (nn - dly) / div;
      cc    = int'(q % ht);
      rr    = int'((q / ht) % vt);
      e.hs  = !((cc >= hv + hfp) && (cc < hv + hfp + hsw));
      e.vs  = !((rr >= vv + vfp) && (rr < vv + vfp + vsw));
      e.von = (cc < hv) && (rr < vv);
    end
    return e;
  endfunction

  function automatic logic [24:0] pack(input exp_t e);
    return {e.r[9:0], e.c[9:0], e.pe, e.hs, e.vs, e.von, e.fs};
  endfunction

  function automatic logic [24:0] m_def(input longint nn);
    return pack(model(nn, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1));
  endfunction

  function automatic logic [24:0] m_sml(input longint nn);
    return pack(model(nn, 20, 4, 6, 5, 10, 2, 3, 4, 3, 2));
  endfunction

  function automatic logic [24:0] m_cor(input longint nn);
    return pack(model(nn, 640, 16, 96, 48, 480, 10, 2, 33, 1, 3));
  endfunction

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [24:0] want_2, want_1;
    want_2 = {20'd0, 5'b01100};
    want_1 = {20'd0, 5'b11100};
    do_reset(3);
    repeat ($urandom_range(300, 1500)) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (d_obs !== want_2) begin n_bad++; $display("FAIL reset_def got %h want %h", d_obs, want_2); end
    n_cmp++;
    if (s_obs !== want_2) begin n_bad++; $display("FAIL reset_sml got %h want %h", s_obs, want_2); end
    n_cmp++;
    if (k_obs !== want_1) begin n_bad++; $display("FAIL reset_cor got %h want %h", k_obs, want_1); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (d_obs !== want_2) begin n_bad++; $display("FAIL reset_hold got %h want %h", d_obs, want_2); end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({d_c, d_pe} !== {10'd0, 1'b0}) begin n_bad++; $display("FAIL release_e0 got c=%0d pe=%b want c=0 pe=0", d_c, d_pe); end
    @(negedge clk);
    n_cmp++;
    if ({d_c, d_pe} !== {10'd0, 1'b1}) begin n_bad++; $display("FAIL release_e1 got c=%0d pe=%b want c=0 pe=1", d_c, d_pe); end
    @(negedge clk);
    n_cmp++;
    if ({d_c, d_pe} !== {10'd1, 1'b0}) begin n_bad++; $display("FAIL release_e2 got c=%0d pe=%b want c=1 pe=0", d_c, d_pe); end
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(200, 2500);
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        n_cmp++;
        if (d_obs !== m_def(n)) begin n_bad++; $display("FAIL rand_def n=%0d got %h want %h", n, d_obs, m_def(n)); end
        n_cmp++;
        if (s_obs !== m_sml(n)) begin n_bad++; $display("FAIL rand_sml n=%0d got %h want %h", n, s_obs, m_sml(n)); end
        n_cmp++;
        if (k_obs !== m_cor(n)) begin n_bad++; $display("FAIL rand_cor n=%0d got %h want %h", n, k_obs, m_cor(n)); end
      end
      @(negedge clk);
      if ($urandom_range(0, 1) == 1) #2;
      else #7;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (d_obs !== m_def(0)) begin n_bad++; $display("FAIL rand_rst_def got %h want %h", d_obs, m_def(0)); end
      n_cmp++;
      if (s_obs !== m_sml(0)) begin n_bad++; $display("FAIL rand_rst_sml got %h want %h", s_obs, m_sml(0)); end
      n_cmp++;
      if (k_obs !== m_cor(0)) begin n_bad++; $display("FAIL rand_rst_cor got %h want %h", k_obs, m_cor(0)); end
      repeat ($urandom_range(1, 4)) @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  task automatic test_line_wrap();
    // Row 10, column 799 is pixel 8799; its pix_en clk is edge 2*8799+1.
    longint target;
    target = 2 * (10 * 800 + 799) + 1;
    do_reset(2);
    for (int i = 0; i < 20000 && n < target; i++) @(negedge clk);
    n_cmp++;
    if ({d_r, d_c, d_pe} !== {10'd10, 10'd799, 1'b1}) begin
      n_bad++; $display("FAIL line_pre got r=%0d c=%0d pe=%b want r=10 c=799 pe=1", d_r, d_c, d_pe);
    end
    @(negedge clk);
    n_cmp++;
    if ({d_r, d_c, d_von} !== {10'd11, 10'd0, 1'b0}) begin
      n_bad++; $display("FAIL line_wrap got r=%0d c=%0d von=%b want r=11 c=0 von=0", d_r, d_c, d_von);
    end
    @(negedge clk);
    n_cmp++;
    if (d_von !== 1'b1) begin n_bad++; $display("FAIL line_von_rise got %b want 1", d_von); end
  endtask

  task automatic test_hsync();
    longint t656, t752, tf, tr;
    int     low;
    logic   prev;
    t656 = -1; t752 = -1; tf = -1; tr = -1; low = 0;
    prev = d_hs;
    for (int i = 0; i < 1700 && tr < 0; i++) begin
      @(negedge clk);
      if (d_c == 10'd656 && t656 < 0) t656 = n;
      if (d_c == 10'd752 && t752 < 0) t752 = n;
      if (prev && !d_hs && tf < 0) tf = n;
      if (!prev && d_hs && tf >= 0 && tr < 0) tr = n;
      if (!d_hs) low++;
      prev = d_hs;
    end
    n_cmp++;
    if (t656 < 0 || tf - t656 != 1) begin n_bad++; $display("FAIL hs_fall_delay got %0d want 1", tf - t656); end
    n_cmp++;
    if (t752 < 0 || tr < 0 || tr - t752 != 1) begin n_bad++; $display("FAIL hs_rise_delay got %0d want 1", tr - t752); end
    n_cmp++;
    if (low != 96 * 2) begin n_bad++; $display("FAIL hs_low_clks got %0d want %0d", low, 96 * 2); end
  endtask

  task automatic test_frame_wrap();
    longint t1, t2;
    int     vlow;
    t1 = -1; t2 = -1; vlow = 0;
    for (int i = 0; i < 2100 && t1 < 0; i++) begin
      @(negedge clk);
      if (s_fs) t1 = n;
    end
    n_cmp++;
    if (t1 < 0 || {s_r, s_c, s_pe} !== {10'd18, 10'd34, 1'b1}) begin
      n_bad++; $display("FAIL frame_pre got r=%0d c=%0d pe=%b want r=18 c=34 pe=1", s_r, s_c, s_pe);
    end
    @(negedge clk);
    n_cmp++;
    if ({s_fs, s_r, s_c} !== {1'b0, 10'd0, 10'd0}) begin
      n_bad++; $display("FAIL frame_wrap got fs=%b r=%0d c=%0d want fs=0 r=0 c=0", s_fs, s_r, s_c);
    end
    if (!s_vs) vlow++;
    for (int i = 0; i < 2100 && t2 < 0; i++) begin
      @(negedge clk);
      if (s_fs) t2 = n;
      if (!s_vs) vlow++;
    end
    n_cmp++;
    if (t1 < 0 || t2 < 0 || t2 - t1 != 35 * 19 * 3) begin
      n_bad++; $display("FAIL frame_period got %0d want %0d", t2 - t1, 35 * 19 * 3);
    end
    n_cmp++;
    if (vlow != 3 * 35 * 3) begin n_bad++; $display("FAIL vs_low_clks got %0d want %0d", vlow, 3 * 35 * 3); end
  endtask

  task automatic test_blanking();
    bit found;
    int ones;
    found = 1'b0;
    for (int i = 0; i < 2100 && !found; i++) begin
      @(negedge clk);
      if (s_r == 10'd5 && s_c == 10'd20) found = 1'b1;
    end
    @(negedge clk);
    n_cmp++;
    if (!found || s_von !== 1'b1) begin n_bad++; $display("FAIL blank_hold got %b want 1", s_von); end
    @(negedge clk);
    n_cmp++;
    if (s_von !== 1'b0) begin n_bad++; $display("FAIL blank_fall got %b want 0", s_von); end
    found = 1'b0;
    for (int i = 0; i < 2100 && !found; i++) begin
      @(negedge clk);
      if (s_r == 10'd10 && s_c == 10'd0) found = 1'b1;
    end
    ones = 0;
    for (int i = 0; i < 35 * 3; i++) begin
      @(negedge clk);
      if (s_von) ones++;
    end
    n_cmp++;
    if (!found || ones != 0) begin n_bad++; $display("FAIL blank_row got %0d visible clks want 0", ones); end
  endtask

  task automatic test_corner();
    bit   found;
    int   bad_pe, bad_inc, prev_c, c0, r0;
    logic h0, h2, h3;
    found = 1'b0;
    for (int i = 0; i < 900 && !found; i++) begin
      @(negedge clk);
      if (k_c == 10'd656) found = 1'b1;
    end
    h0 = k_hs;
    @(negedge clk);
    @(negedge clk);
    h2 = k_hs;
    @(negedge clk);
    h3 = k_hs;
    n_cmp++;
    if (!found || {h0, h2, h3} !== 3'b110) begin
      n_bad++; $display("FAIL cor_hs_fall got %b%b%b want 110", h0, h2, h3);
    end
    c0 = int'(k_c);
    r0 = int'(k_r);
    prev_c = c0;
    bad_pe = 0;
    bad_inc = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (!k_pe) bad_pe++;
      if (int'(k_c) != (prev_c + 1) % 800) bad_inc++;
      prev_c = int'(k_c);
    end
    n_cmp++;
    if (bad_pe != 0) begin n_bad++; $display("FAIL cor_pix_en got %0d low clks want 0", bad_pe); end
    n_cmp++;
    if (bad_inc != 0) begin n_bad++; $display("FAIL cor_c_step got %0d bad steps want 0", bad_inc); end
    n_cmp++;
    if (int'(k_c) != c0 || int'(k_r) != (r0 + 1) % 525) begin
      n_bad++; $display("FAIL cor_line_period got r=%0d c=%0d want r=%0d c=%0d", k_r, k_c, (r0 + 1) % 525, c0);
    end
  endtask

  initial begin
    test_reset();
    test_random();
    test_line_wrap();
    test_hsync();
    test_frame_wrap();
    test_blanking();
    test_corner();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
